// File: rtl/lanes_tx_sequencer.sv
// lanes_tx_sequencer
// Sequencing controller in front of the two-lane transmit serializer. It buffers
// one 132-bit word pair from upstream (valid/ready), presents it on the serializer
// load cycles, gates the serializer enable, freezes the speed code while
// transmitting, drains the in-flight word on link-down, and counts sent words
// and underruns.
//
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   link_up_i           transmit request (level)
//   gen_speed_i         requested speed code, latched only when leaving idle
//   word_valid_i        upstream word pair available
//   lane_0/1_word_i     upstream lane words
//   word_ready_o        word pair accepted when high together with word_valid_i
//   ser_load_i          serializer load-cycle indicator (its counter == 0)
//   ser_enable_o        serializer enable
//   ser_gen_speed_o     latched speed code
//   lane_0/1_ser_in_o   hold register contents, or zero when empty
//   busy_o              controller not idle
//   underrun_o          one-cycle pulse after a load with an empty hold register
//   words_sent_o        wrapping count of real words loaded
module lanes_tx_sequencer (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         link_up_i,
  input  logic [1:0]   gen_speed_i,
  input  logic         word_valid_i,
  input  logic [131:0] lane_0_word_i,
  input  logic [131:0] lane_1_word_i,
  output logic         word_ready_o,
  input  logic         ser_load_i,
  output logic         ser_enable_o,
  output logic [1:0]   ser_gen_speed_o,
  output logic [131:0] lane_0_ser_in_o,
  output logic [131:0] lane_1_ser_in_o,
  output logic         busy_o,
  output logic         underrun_o,
  output logic [15:0]  words_sent_o
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFill  = 2'd1,
    StRun   = 2'd2,
    StDrain = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [131:0]  hold0_q, hold0_d;
  logic [131:0]  hold1_q, hold1_d;
  logic          hold_valid_q, hold_valid_d;
  logic [1:0]    speed_q, speed_d;
  logic          underrun_q, underrun_d;
  logic [15:0]   words_sent_q, words_sent_d;

  logic          ser_enable;
  logic          word_ready;
  logic          load_now;
  logic          accept;
  logic          flush;

  // Control FSM: next state, speed latch, enable and ready.
  always_comb begin
    state_d    = state_q;
    speed_d    = speed_q;
    ser_enable = 1'b0;
    word_ready = 1'b0;
    flush      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (link_up_i) begin
          speed_d = gen_speed_i;
          state_d = StFill;
        end
      end
      StFill: begin
        word_ready = !hold_valid_q;
        if (!link_up_i) begin
          state_d = StIdle;
          flush   = 1'b1;
        end else if (hold_valid_q) begin
          state_d = StRun;
        end
      end
      StRun: begin
        ser_enable = 1'b1;
        word_ready = !hold_valid_q || ser_load_i;
        // A load coinciding with link-down still completes; drain covers it.
        if (!link_up_i) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // Enable falls on the load cycle so the serializer stops without reloading.
        ser_enable = !ser_load_i;
        if (ser_load_i) begin
          state_d = StIdle;
          flush   = 1'b1;
        end
      end
    endcase
  end

  assign load_now = ser_enable & ser_load_i;
  assign accept   = word_valid_i & word_ready;

  // Hold register and counters.
  always_comb begin
    hold0_d      = hold0_q;
    hold1_d      = hold1_q;
    hold_valid_d = hold_valid_q;
    if (load_now) begin
      hold_valid_d = 1'b0;
    end
    // An accept on a load cycle replaces the word being loaded.
    if (accept) begin
      hold0_d      = lane_0_word_i;
      hold1_d      = lane_1_word_i;
      hold_valid_d = 1'b1;
    end
    if (flush) begin
      hold_valid_d = 1'b0;
    end
    underrun_d   = load_now & !hold_valid_q;
    words_sent_d = words_sent_q + {15'd0, load_now & hold_valid_q};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      hold0_q      <= '0;
      hold1_q      <= '0;
      hold_valid_q <= 1'b0;
      speed_q      <= 2'b00;
      underrun_q   <= 1'b0;
      words_sent_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      hold0_q      <= hold0_d;
      hold1_q      <= hold1_d;
      hold_valid_q <= hold_valid_d;
      speed_q      <= speed_d;
      underrun_q   <= underrun_d;
      words_sent_q <= words_sent_d;
    end
  end

  assign word_ready_o    = word_ready;
  assign ser_enable_o    = ser_enable;
  assign ser_gen_speed_o = speed_q;
  assign lane_0_ser_in_o = hold_valid_q ? hold0_q : '0;
  assign lane_1_ser_in_o = hold_valid_q ? hold1_q : '0;
  assign busy_o          = (state_q != StIdle);
  assign underrun_o      = underrun_q;
  assign words_sent_o    = words_sent_q;

endmodule

// File: tb/tb_lanes_tx_sequencer.sv
module tb_lanes_tx_sequencer;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         link_up_i = 1'b0;
  logic [1:0]   gen_speed_i = 2'b00;
  logic         word_valid_i = 1'b0;
  logic [131:0] lane_0_word_i;
  logic [131:0] lane_1_word_i;
  logic         word_ready_o;
  logic         ser_load;
  logic         ser_enable_o;
  logic [1:0]   ser_gen_speed_o;
  logic [131:0] lane_0_ser_in_o;
  logic [131:0] lane_1_ser_in_o;
  logic         busy_o;
  logic         underrun_o;
  logic [15:0]  words_sent_o;

  int n_tests = 0;
  int n_fail  = 0;

  int cyc     = 0;
  int acc_idx = 0;
  int ser_cnt = 0;
  logic force_load = 1'b0;

  int           ld_cyc[$];
  logic [131:0] ld0[$];
  logic [131:0] ld1[$];
  int           ur_cyc[$];

  lanes_tx_sequencer dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .link_up_i       (link_up_i),
    .gen_speed_i     (gen_speed_i),
    .word_valid_i    (word_valid_i),
    .lane_0_word_i   (lane_0_word_i),
    .lane_1_word_i   (lane_1_word_i),
    .word_ready_o    (word_ready_o),
    .ser_load_i      (ser_load),
    .ser_enable_o    (ser_enable_o),
    .ser_gen_speed_o (ser_gen_speed_o),
    .lane_0_ser_in_o (lane_0_ser_in_o),
    .lane_1_ser_in_o (lane_1_ser_in_o),
    .busy_o          (busy_o),
    .underrun_o      (underrun_o),
    .words_sent_o    (words_sent_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [131:0] mk(input int lane, input int idx);
    return {4'(lane), 64'hC0DE_5A5A_0000_0000 ^ 64'(idx * 3), 64'(idx)};
  endfunction

  function automatic int ser_n(input logic [1:0] s);
    case (s)
      2'b01:   return 132;
      2'b10:   return 66;
      default: return 8;
    endcase
  endfunction

  // Upstream source: word pair indexed by number of accepted words.
  assign lane_0_word_i = mk(0, acc_idx);
  assign lane_1_word_i = mk(1, acc_idx);

  // Serializer model: counter runs while enabled, load when it is zero.
  assign ser_load = force_load | (ser_cnt == 0);

  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (word_valid_i && word_ready_o) acc_idx <= acc_idx + 1;
    if (!ser_enable_o) ser_cnt <= 0;
    else if (ser_cnt == ser_n(ser_gen_speed_o) - 1) ser_cnt <= 0;
    else ser_cnt <= ser_cnt + 1;
  end

  // Mid-cycle monitor of loads and underrun pulses.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (ser_enable_o && ser_load) begin
        ld_cyc.push_back(cyc);
        ld0.push_back(lane_0_ser_in_o);
        ld1.push_back(lane_1_ser_in_o);
      end
      if (underrun_o) ur_cyc.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni       = 1'b0;
    link_up_i    = 1'b0;
    word_valid_i = 1'b0;
    gen_speed_i  = 2'b00;
    force_load   = 1'b0;
    step();
    step();
    rst_ni = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (ser_enable_o !== 1'b0) begin n_fail++; $display("FAIL rst_enable: got %b want 0", ser_enable_o); end
    n_tests++; if (word_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", word_ready_o); end
    n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy_o); end
    n_tests++; if (underrun_o !== 1'b0) begin n_fail++; $display("FAIL rst_underrun: got %b want 0", underrun_o); end
    n_tests++; if (words_sent_o !== 16'd0) begin n_fail++; $display("FAIL rst_words: got %h want 0", words_sent_o); end
    n_tests++; if (ser_gen_speed_o !== 2'b00) begin n_fail++; $display("FAIL rst_speed: got %b want 00", ser_gen_speed_o); end
    n_tests++; if (lane_0_ser_in_o !== 132'd0 || lane_1_ser_in_o !== 132'd0) begin n_fail++; $display("FAIL rst_lanes: got %h %h want 0", lane_0_ser_in_o, lane_1_ser_in_o); end
  endtask

  task automatic test_gen66();
    int b, ub, ib;
    bit ok;
    do_reset();
    b = ld_cyc.size(); ub = ur_cyc.size(); ib = acc_idx;
    link_up_i = 1'b1; gen_speed_i = 2'b10; word_valid_i = 1'b1;
    step();
    n_tests++; if (busy_o !== 1'b1 || ser_enable_o !== 1'b0 || word_ready_o !== 1'b1) begin n_fail++; $display("FAIL g66_fill: busy/en/rdy got %b%b%b want 101", busy_o, ser_enable_o, word_ready_o); end
    step();
    n_tests++; if (ser_enable_o !== 1'b0 || word_ready_o !== 1'b0) begin n_fail++; $display("FAIL g66_fill2: en/rdy got %b%b want 00", ser_enable_o, word_ready_o); end
    step();
    n_tests++; if (ser_enable_o !== 1'b1 || ser_gen_speed_o !== 2'b10) begin n_fail++; $display("FAIL g66_run: en/speed got %b %b want 1 10", ser_enable_o, ser_gen_speed_o); end
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (ld_cyc.size() >= b + 10) begin ok = 1'b1; break; end
      step();
    end
    n_tests++;
    if (!ok) begin
      n_fail++; $display("FAIL g66_timeout: got %0d loads want 10", ld_cyc.size() - b);
    end else begin
      if (words_sent_o !== 16'd10) begin n_fail++; $display("FAIL g66_words: got %0d want 10", words_sent_o); end
      n_tests++; if (ld_cyc[b+1] - ld_cyc[b] != 66) begin n_fail++; $display("FAIL g66_period: got %0d want 66", ld_cyc[b+1] - ld_cyc[b]); end
      n_tests++; if (ld_cyc[b+9] - ld_cyc[b] != 594) begin n_fail++; $display("FAIL g66_span: got %0d want 594", ld_cyc[b+9] - ld_cyc[b]); end
      n_tests++; if (ld0[b] !== mk(0, ib)) begin n_fail++; $display("FAIL g66_first: got %h want %h", ld0[b], mk(0, ib)); end
      n_tests++; if (ld1[b+9] !== mk(1, ib + 9)) begin n_fail++; $display("FAIL g66_tenth: got %h want %h", ld1[b+9], mk(1, ib + 9)); end
      n_tests++; if (ur_cyc.size() != ub) begin n_fail++; $display("FAIL g66_underrun: got %0d pulses want 0", ur_cyc.size() - ub); end
    end
  endtask

  task automatic test_underrun();
    int b, ub, ib;
    bit ok;
    do_reset();
    b = ld_cyc.size(); ub = ur_cyc.size(); ib = acc_idx;
    link_up_i = 1'b1; gen_speed_i = 2'b00; word_valid_i = 1'b1;
    step();
    step();
    word_valid_i = 1'b0;
    step();
    repeat (20) step();
    word_valid_i = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (ld_cyc.size() >= b + 5) begin ok = 1'b1; break; end
      step();
    end
    n_tests++;
    if (!ok) begin
      n_fail++; $display("FAIL ur_timeout: got %0d loads want 5", ld_cyc.size() - b);
    end else begin
      if (words_sent_o !== 16'd3) begin n_fail++; $display("FAIL ur_words: got %0d want 3", words_sent_o); end
      n_tests++; if (ld0[b+1] !== 132'd0 || ld1[b+1] !== 132'd0 || ld0[b+2] !== 132'd0 || ld1[b+2] !== 132'd0) begin n_fail++; $display("FAIL ur_zeros: got %h %h want 0", ld0[b+1], ld1[b+2]); end
      n_tests++; if (ld0[b+3] !== mk(0, ib + 1)) begin n_fail++; $display("FAIL ur_resume: got %h want %h", ld0[b+3], mk(0, ib + 1)); end
      n_tests++; if (ur_cyc.size() - ub != 2) begin n_fail++; $display("FAIL ur_count: got %0d want 2", ur_cyc.size() - ub); end
      else begin
        n_tests++; if (ur_cyc[ub] != ld_cyc[b+1] + 1 || ur_cyc[ub+1] != ld_cyc[b+2] + 1) begin n_fail++; $display("FAIL ur_timing: got %0d %0d want %0d %0d", ur_cyc[ub], ur_cyc[ub+1], ld_cyc[b+1] + 1, ld_cyc[b+2] + 1); end
      end
    end
  endtask

  task automatic test_drain();
    int b, ib;
    bit ok;
    do_reset();
    b = ld_cyc.size(); ib = acc_idx;
    link_up_i = 1'b1; gen_speed_i = 2'b01; word_valid_i = 1'b1;
    repeat (3) step();
    repeat (10) step();
    link_up_i = 1'b0;
    step();
    n_tests++; if (busy_o !== 1'b1 || ser_enable_o !== 1'b1 || word_ready_o !== 1'b0) begin n_fail++; $display("FAIL dr_enter: busy/en/rdy got %b%b%b want 110", busy_o, ser_enable_o, word_ready_o); end
    n_tests++; if (lane_0_ser_in_o !== mk(0, ib + 1)) begin n_fail++; $display("FAIL dr_pending: got %h want %h", lane_0_ser_in_o, mk(0, ib + 1)); end
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!ser_enable_o) begin ok = 1'b1; break; end
      step();
    end
    n_tests++;
    if (!ok) begin
      n_fail++; $display("FAIL dr_timeout: got enable %b want 0", ser_enable_o);
    end else begin
      if (ser_load !== 1'b1 || busy_o !== 1'b1) begin n_fail++; $display("FAIL dr_fall: load/busy got %b%b want 11", ser_load, busy_o); end
      n_tests++; if (cyc - ld_cyc[b] != 132) begin n_fail++; $display("FAIL dr_when: got %0d want 132", cyc - ld_cyc[b]); end
      step();
      n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL dr_idle: got busy %b want 0", busy_o); end
      n_tests++; if (lane_0_ser_in_o !== 132'd0 || lane_1_ser_in_o !== 132'd0) begin n_fail++; $display("FAIL dr_discard: got %h want 0", lane_0_ser_in_o); end
      n_tests++; if (ld_cyc.size() != b + 1 || words_sent_o !== 16'd1) begin n_fail++; $display("FAIL dr_loads: got %0d loads %0d words want 1 1", ld_cyc.size() - b, words_sent_o); end
    end
  endtask

  task automatic test_speed_freeze();
    bit ok;
    do_reset();
    link_up_i = 1'b1; gen_speed_i = 2'b01; word_valid_i = 1'b1;
    repeat (3) step();
    gen_speed_i = 2'b10;
    repeat (5) step();
    n_tests++; if (ser_gen_speed_o !== 2'b01) begin n_fail++; $display("FAIL sp_frozen: got %b want 01", ser_gen_speed_o); end
    link_up_i = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!busy_o) begin ok = 1'b1; break; end
      step();
    end
    n_tests++;
    if (!ok) begin
      n_fail++; $display("FAIL sp_timeout: got busy %b want 0", busy_o);
    end else begin
      if (ser_gen_speed_o !== 2'b01) begin n_fail++; $display("FAIL sp_idle: got %b want 01", ser_gen_speed_o); end
      link_up_i = 1'b1;
      step();
      n_tests++; if (ser_gen_speed_o !== 2'b10 || busy_o !== 1'b1) begin n_fail++; $display("FAIL sp_relatch: speed/busy got %b %b want 10 1", ser_gen_speed_o, busy_o); end
    end
  endtask

  task automatic test_async_reset();
    int ib;
    do_reset();
    ib = acc_idx;
    link_up_i = 1'b1; gen_speed_i = 2'b00; word_valid_i = 1'b1;
    repeat (4) step();
    n_tests++; if (lane_0_ser_in_o !== mk(0, ib + 1) || words_sent_o !== 16'd1 || busy_o !== 1'b1) begin n_fail++; $display("FAIL ar_pre: got %h %0d %b want %h 1 1", lane_0_ser_in_o, words_sent_o, busy_o, mk(0, ib + 1)); end
    rst_ni = 1'b0;
    #1;
    n_tests++; if (ser_enable_o !== 1'b0 || word_ready_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL ar_ctrl: en/rdy/busy got %b%b%b want 000", ser_enable_o, word_ready_o, busy_o); end
    n_tests++; if (lane_0_ser_in_o !== 132'd0 || lane_1_ser_in_o !== 132'd0) begin n_fail++; $display("FAIL ar_lanes: got %h %h want 0", lane_0_ser_in_o, lane_1_ser_in_o); end
    n_tests++; if (words_sent_o !== 16'd0 || underrun_o !== 1'b0 || ser_gen_speed_o !== 2'b00) begin n_fail++; $display("FAIL ar_regs: words/ur/speed got %h %b %b want 0 0 00", words_sent_o, underrun_o, ser_gen_speed_o); end
  endtask

  task automatic test_wrap();
    int b, ub;
    bit ok;
    do_reset();
    b = ld_cyc.size(); ub = ur_cyc.size();
    force_load = 1'b1;
    link_up_i = 1'b1; gen_speed_i = 2'b00; word_valid_i = 1'b1;
    repeat (3) step();
    ok = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      if (words_sent_o === 16'hFFFF) begin ok = 1'b1; break; end
      step();
    end
    n_tests++;
    if (!ok) begin
      n_fail++; $display("FAIL wr_timeout: got %h want FFFF", words_sent_o);
    end else begin
      if (ld_cyc.size() - b != 65535) begin n_fail++; $display("FAIL wr_loads: got %0d want 65535", ld_cyc.size() - b); end
      step();
      n_tests++; if (words_sent_o !== 16'h0000) begin n_fail++; $display("FAIL wr_wrap: got %h want 0000", words_sent_o); end
      n_tests++; if (ur_cyc.size() != ub) begin n_fail++; $display("FAIL wr_underrun: got %0d want 0", ur_cyc.size() - ub); end
    end
    force_load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_gen66();
    test_underrun();
    test_drain();
    test_speed_freeze();
    test_async_reset();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
